fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage for NLP-16AF. Sits directly upstream of the instruction decoder.
- Owns the fetch pointer and issues 16-bit word reads on the memory bus.
- Buffers fetched words in a small prefetch queue and hands them to the decoder one word at a time (IR1, IR2, immediate) over a valid/take handshake.
- Supports redirect (jump/call/return) with queue flush and drop of any in-flight read.

Parameters:
- ADDR_W, 16, memory word-address width
- DATA_W, 16, instruction word width
- QDEPTH, 2, prefetch queue entries (power of two, ≥2)
- RESET_IP, 16'h0000, fetch pointer value after reset

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- o_mem_req  out  1  read request
- o_mem_addr  out  ADDR_W  read word address
- i_mem_ack  in  1  read complete; i_mem_rdata valid this cycle
- i_mem_rdata  in  DATA_W  read data
- o_ir_data  out  DATA_W  queue head word
- o_ir_addr  out  ADDR_W  address of head word
- o_ir_valid  out  1  head word valid
- i_ir_take  in  1  decoder consumes head word this cycle
- i_redirect  in  1  load new fetch address, flush queue
- i_redirect_addr  in  ADDR_W  new fetch address
- o_busy  out  1  read outstanding or DISCARD active

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - o_mem_req=0, o_mem_addr=RESET_IP, fetch pointer=RESET_IP
  - queue empty: o_ir_valid=0, o_ir_data=0, o_ir_addr=RESET_IP
  - o_busy=0, state IDLE
  - Reset mid-transaction abandons any in-flight read; an ack arriving after reset is ignored.
- State machine (enum in package): IDLE, REQ, DISCARD.
  - IDLE: if queue count < QDEPTH, go to REQ next cycle with o_mem_req=1 and o_mem_addr=fetch pointer.
  - REQ: o_mem_req and o_mem_addr held stable until i_mem_ack. Ack may arrive in the first cycle of req (zero-wait).
    - On ack: push i_mem_rdata with its address; fetch pointer +1, wrapping 16'hFFFF→16'h0000.
    - Then stay in REQ with the next address if count after push/pop < QDEPTH, else go to IDLE.
  - DISCARD: entered on redirect while REQ and no ack this cycle. o_mem_req/o_mem_addr stay at the old address until ack; that data is dropped. Then go to REQ at the redirect address.
- Sustained rate: one word per cycle with zero-wait memory when the decoder takes every cycle.
- At most one read outstanding.
- Redirect (highest priority):
  - Same cycle: queue flushed, i_ir_take ignored, fetch pointer <= i_redirect_addr.
  - Next cycle: o_ir_valid=0.
  - If ack coincides with redirect, that data is dropped and next state is REQ at the new address.
  - Redirect while in DISCARD: updates the target only.
- Queue:
  - o_ir_valid = count≠0.
  - Take with o_ir_valid=0 is ignored.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Push never occurs when full; a request is only issued if space is reserved.
- Latency: first o_mem_req in the first cycle after i_rst deasserts. Head valid the cycle after ack.
- o_busy = state≠IDLE.

Decomposition:
- nlp16af_pkg holds:
  - fetch_state_e (IDLE, REQ, DISCARD)
  - NLP_WORD_W=16 and NLP_ADDR_W=16 constants
- One sub-module: fetch_queue, a parametric FIFO of {addr,data} with push/pop/flush and count outputs.

Test Plan:
- Reset release, zero-wait ack, data 16'h1234 then 16'h5678, take every cycle → o_mem_addr 0,1,2…; o_ir_data 1234 @addr0 then 5678 @addr1; one word/cycle.
- Decoder never takes → after 2 acks o_mem_req=0, queue full (count 2). Single take → exactly one new req at addr 2.
- Redirect to 16'h0040 while req pending, ack 3 cycles later with 16'hDEAD → DEAD never appears. Next req addr 0040; o_ir_valid=0 in between.
- Redirect coincident with ack and take → acked word dropped, queue empty next cycle, next req addr = redirect addr.
- Redirect to 16'hFFFF, two acks → addresses FFFF then 0000, o_ir_addr follows.
- Assert i_rst mid-REQ, late ack afterwards → outputs at reset values, ack ignored, fetch restarts at RESET_IP.

Source files
------------

// File: rtl/nlp16af_pkg.sv
// Shared types and widths for the NLP-16AF front end.
package nlp16af_pkg;

  localparam int NLP_WORD_W = 16;
  localparam int NLP_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of {addr, data} pairs with flush; head is read combinationally.
module fetch_queue
  import nlp16af_pkg::*;
#(
  parameter int                DEPTH      = 2,
  parameter int                ADDR_W     = NLP_ADDR_W,
  parameter int                DATA_W     = NLP_WORD_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data,
  output logic [CNT_W-1:0]  o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    do_push    = i_push && (count_q != CNT_W'(DEPTH));
    do_pop     = i_pop && (count_q != '0);
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        addr_mem_d[wr_ptr_q] = i_push_addr;
        data_mem_d[wr_ptr_q] = i_push_data;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= RESET_ADDR;
        data_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign o_head_addr = addr_mem_q[rd_ptr_q];
  assign o_head_data = data_mem_q[rd_ptr_q];
  assign o_count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch pointer, issues one word read at a time,
// and feeds a prefetch queue to the decoder; redirect flushes and drops stale reads.
module fetch_unit
  import nlp16af_pkg::*;
#(
  parameter int                ADDR_W   = NLP_ADDR_W,
  parameter int                DATA_W   = NLP_WORD_W,
  parameter int                QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_IP = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_ir_data,
  output logic [ADDR_W-1:0] o_ir_addr,
  output logic              o_ir_valid,
  input  logic              i_ir_take,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  output logic              o_busy
);

  localparam int               CNT_W    = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  // Handshakes: the memory side holds o_mem_req/o_mem_addr until i_mem_ack (which may
  // arrive in the request's first cycle); the decoder side consumes the head word in any
  // cycle with o_ir_valid && i_ir_take, except that i_redirect overrides the take.
  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] ptr_inc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              ir_valid, push, pop;

  assign ir_valid    = (count != '0);
  assign ptr_inc     = ptr_q + ADDR_W'(1);
  assign pop         = i_ir_take && ir_valid && !i_redirect;
  assign count_after = count + CNT_W'(1) - CNT_W'(pop);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_redirect) begin
          ptr_d   = i_redirect_addr;
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = i_redirect_addr;
        end else if (count < FULL_CNT) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = ptr_q;
        end
      end
      REQ: begin
        if (i_mem_ack && i_redirect) begin
          ptr_d  = i_redirect_addr;
          req_d  = 1'b1;
          addr_d = i_redirect_addr;
        end else if (i_mem_ack) begin
          push   = 1'b1;
          ptr_d  = ptr_inc;
          addr_d = ptr_inc;
          // Only keep requesting if the pushed word still leaves a free slot.
          if (count_after < FULL_CNT) begin
            req_d = 1'b1;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end else if (i_redirect) begin
          ptr_d   = i_redirect_addr;
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (i_redirect) begin
          ptr_d = i_redirect_addr;
        end
        if (i_mem_ack) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = ptr_d;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= RESET_IP;
      ptr_q   <= RESET_IP;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
    end
  end

  fetch_queue #(
    .DEPTH      (QDEPTH),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RESET_ADDR (RESET_IP),
    .CNT_W      (CNT_W)
  ) u_queue (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_flush     (i_redirect),
    .i_push      (push),
    .i_push_addr (addr_q),
    .i_push_data (i_mem_rdata),
    .i_pop       (pop),
    .o_head_addr (head_addr),
    .o_head_data (head_data),
    .o_count     (count)
  );

  assign o_mem_req  = req_q;
  assign o_mem_addr = addr_q;
  assign o_busy     = busy_q;
  assign o_ir_valid = ir_valid;
  assign o_ir_data  = ir_valid ? head_data : '0;
  assign o_ir_addr  = ir_valid ? head_addr : RESET_IP;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder and decoder driver with a queue-based
// model of the words the decoder should see and the addresses that should be fetched.
module tb_fetch_unit;

  localparam int          QDEPTH = 2;
  localparam logic [15:0] RST_IP = 16'h0000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [15:0] i_mem_rdata = '0;
  logic [15:0] o_ir_data;
  logic [15:0] o_ir_addr;
  logic        o_ir_valid;
  logic        i_ir_take = 1'b0;
  logic        i_redirect = 1'b0;
  logic [15:0] i_redirect_addr = '0;
  logic        o_busy;

  fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .QDEPTH   (QDEPTH),
    .RESET_IP (RST_IP)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .o_mem_req       (o_mem_req),
    .o_mem_addr      (o_mem_addr),
    .i_mem_ack       (i_mem_ack),
    .i_mem_rdata     (i_mem_rdata),
    .o_ir_data       (o_ir_data),
    .o_ir_addr       (o_ir_addr),
    .o_ir_valid      (o_ir_valid),
    .i_ir_take       (i_ir_take),
    .i_redirect      (i_redirect),
    .i_redirect_addr (i_redirect_addr),
    .o_busy          (o_busy)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];          // {addr, data} words the decoder should see, in order
  logic [15:0] force_data_q[$];   // data to return on the next acks
  logic [15:0] exp_ptr = RST_IP;  // next address a fresh request must use
  logic        pend_v = 1'b0;
  logic        pend_stale = 1'b0;
  logic [15:0] pend_addr = '0;
  int          idle_cycles = 0;
  int          push_cnt = 0;
  int          new_req_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  // knobs, the *_once ones clear after each tick
  int          take_pct = 0;
  int          ack_pct = 0;
  logic        take_once = 0, ack_once = 0, ack_force = 0, rst_once = 0, redir_once = 0;
  logic [15:0] redir_addr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic observe();
    if (o_mem_req && !pend_v) begin
      check("req_addr", {16'h0, o_mem_addr}, {16'h0, exp_ptr});
      check("req_room", 32'(exp_q.size() < QDEPTH), 32'd1);
      pend_v     = 1'b1;
      pend_stale = 1'b0;
      pend_addr  = exp_ptr;
      new_req_cnt++;
    end
    if (pend_v) begin
      check("req_hold", 32'(o_mem_req), 32'd1);
      check("addr_hold", {16'h0, o_mem_addr}, {16'h0, pend_addr});
    end
    check("busy", 32'(o_busy), 32'(pend_v));
    check("ir_valid", 32'(o_ir_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("ir_head", {o_ir_addr, o_ir_data}, exp_q[0]);
    end
    if (!o_mem_req && exp_q.size() < QDEPTH) idle_cycles++;
    else idle_cycles = 0;
    check("stall", 32'(idle_cycles <= 2), 32'd1);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check at negedge.
  task automatic tick();
    logic        do_ack, do_take, do_redir;
    logic [15:0] rd;
    do_ack   = ack_force || (pend_v && (ack_once || ($urandom_range(99) < ack_pct)));
    do_take  = take_once || ($urandom_range(99) < take_pct);
    do_redir = redir_once;
    rd = 16'($urandom);
    if (do_ack && force_data_q.size() != 0) rd = force_data_q.pop_front();
    i_rst           = rst_once;
    i_mem_ack       = do_ack;
    i_mem_rdata     = rd;
    i_ir_take       = do_take;
    i_redirect      = do_redir;
    i_redirect_addr = do_redir ? redir_addr : 16'($urandom);
    if (rst_once) begin
      exp_q.delete();
      pend_v      = 1'b0;
      pend_stale  = 1'b0;
      exp_ptr     = RST_IP;
      idle_cycles = 0;
    end else if (do_redir) begin
      exp_q.delete();
      exp_ptr = redir_addr;
      if (pend_v) begin
        if (do_ack) pend_v = 1'b0;
        else pend_stale = 1'b1;
      end
    end else begin
      if (do_take && exp_q.size() != 0) void'(exp_q.pop_front());
      if (do_ack && pend_v) begin
        if (!pend_stale) begin
          exp_q.push_back({pend_addr, rd});
          exp_ptr = pend_addr + 16'd1;
          push_cnt++;
        end
        pend_v = 1'b0;
      end
    end
    take_once = 0; ack_once = 0; ack_force = 0; rst_once = 0; redir_once = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    observe();
  endtask

  task automatic check_reset_outputs();
    check("rst_req", 32'(o_mem_req), 32'd0);
    check("rst_addr", {16'h0, o_mem_addr}, {16'h0, RST_IP});
    check("rst_valid", 32'(o_ir_valid), 32'd0);
    check("rst_ir_data", {16'h0, o_ir_data}, 32'h0);
    check("rst_ir_addr", {16'h0, o_ir_addr}, {16'h0, RST_IP});
    check("rst_busy", 32'(o_busy), 32'd0);
  endtask

  task automatic do_reset();
    take_pct = 0;
    ack_pct  = 0;
    force_data_q.delete();
    rst_once = 1;
    tick();
    check_reset_outputs();
  endtask

  initial begin
    int base;
    @(negedge i_clk);

    // zero-wait memory, decoder takes every cycle
    do_reset();
    take_pct = 100;
    ack_pct  = 100;
    force_data_q.push_back(16'h1234);
    force_data_q.push_back(16'h5678);
    tick();
    check("t1_first_addr", {16'h0, o_mem_addr}, 32'h0);
    tick();
    check("t1_head0", {o_ir_addr, o_ir_data}, 32'h0000_1234);
    check("t1_req1", {15'h0, o_mem_req, o_mem_addr}, 32'h0001_0001);
    tick();
    check("t1_head1", {o_ir_addr, o_ir_data}, 32'h0001_5678);
    for (int i = 0; i < 3; i++) tick();
    base = push_cnt;
    for (int i = 0; i < 16; i++) tick();
    check("t1_rate", 32'(push_cnt - base), 32'd16);

    // decoder stalls: queue fills, then one take yields exactly one refill
    do_reset();
    ack_pct = 100;
    for (int i = 0; i < 5; i++) tick();
    check("t2_full_noreq", 32'(o_mem_req), 32'd0);
    check("t2_full_head", {16'h0, o_ir_addr}, 32'h0);
    base = new_req_cnt;
    take_once = 1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("t2_one_refill", 32'(new_req_cnt - base), 32'd1);
    check("t2_refill_addr", {16'h0, pend_addr}, 32'h2);

    // redirect while a read is pending; the late DEAD data must be dropped
    do_reset();
    tick();
    redir_once = 1;
    redir_addr = 16'h0040;
    tick();
    tick();
    tick();
    check("t3_discard_addr", {15'h0, o_mem_req, o_mem_addr}, 32'h0001_0000);
    check("t3_discard_valid", 32'(o_ir_valid), 32'd0);
    force_data_q.push_back(16'hDEAD);
    ack_once = 1;
    tick();
    check("t3_new_addr", {16'h0, o_mem_addr}, 32'h0040);
    check("t3_valid_gap", 32'(o_ir_valid), 32'd0);
    force_data_q.push_back(16'h1111);
    force_data_q.push_back(16'h2222);
    ack_pct = 100;
    tick();
    check("t3_after_head", {o_ir_addr, o_ir_data}, 32'h0040_1111);
    take_pct = 100;
    for (int i = 0; i < 4; i++) tick();

    // redirect coincident with ack and take
    do_reset();
    ack_pct = 100;
    tick();
    tick();
    redir_once = 1;
    redir_addr = 16'h0100;
    take_once  = 1;
    tick();
    check("t4_flushed", 32'(o_ir_valid), 32'd0);
    check("t4_new_addr", {15'h0, o_mem_req, o_mem_addr}, 32'h0001_0100);

    // pointer wrap across FFFF
    do_reset();
    ack_pct    = 100;
    redir_once = 1;
    redir_addr = 16'hFFFF;
    tick();
    tick();
    check("t5_wrap_req", {16'h0, o_mem_addr}, 32'h0000);
    tick();
    check("t5_head_ffff", {16'h0, o_ir_addr}, 32'hFFFF);
    take_once = 1;
    tick();
    check("t5_head_0000", {16'h0, o_ir_addr}, 32'h0000);

    // reset mid-request with a late ack straddling the reset
    do_reset();
    redir_once = 1;
    redir_addr = 16'h0300;
    tick();
    tick();
    force_data_q.push_back(16'hBEEF);
    force_data_q.push_back(16'hBEEF);
    ack_force = 1;
    rst_once  = 1;
    tick();
    check_reset_outputs();
    ack_force = 1;
    tick();
    check("t6_restart", {15'h0, o_mem_req, o_mem_addr}, {15'h0, 1'b1, RST_IP});
    check("t6_no_word", 32'(o_ir_valid), 32'd0);
    force_data_q.push_back(16'h7777);
    ack_once = 1;
    tick();
    check("t6_head", {o_ir_addr, o_ir_data}, {RST_IP, 16'h7777});

    // randomized traffic
    for (int blk = 0; blk < 40; blk++) begin
      take_pct = $urandom_range(0, 100);
      ack_pct  = $urandom_range(10, 100);
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(99) < 3) begin
          redir_once = 1;
          case ($urandom_range(3))
            0:       redir_addr = 16'hFFFE + 16'($urandom_range(1));
            1:       redir_addr = 16'($urandom_range(15));
            default: redir_addr = 16'($urandom);
          endcase
        end
        if ($urandom_range(999) < 2) rst_once = 1;
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
